// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: sits behind Execute, performs loads and
// stores against the data memory over an enable/busy handshake and hands a
// registered writeback packet (or an error pulse) to the next stage.
// Buses use [0:31] ordering, bit 0 is the MSB; byte lane 0 is bits [0:7].
module mem_access_stage #(
  parameter int         ADDR_W            = 32,
  parameter logic [1:0] ERR_CODE_MISALIGN = 2'b01,
  parameter logic [1:0] ERR_CODE_ILLEGAL  = 2'b10
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            valid_in,
  input  logic [0:ADDR_W-1] alu_result,
  input  logic [0:ADDR_W-1] rt_data,
  input  logic [0:4]      rd_in,
  input  logic            reg_write_in,
  input  logic            is_load,
  input  logic            is_store,
  input  logic [0:1]      mem_size,
  input  logic            load_unsigned,
  output logic            stall_out,
  output logic [0:ADDR_W-1] dmem_addr,
  output logic [0:ADDR_W-1] dmem_wdata,
  output logic [0:3]      dmem_be,
  output logic            dmem_wren,
  output logic            dmem_enable,
  input  logic [0:ADDR_W-1] dmem_rdata,
  input  logic            dmem_busy,
  output logic            wb_valid,
  output logic [0:ADDR_W-1] wb_data,
  output logic [0:4]      wb_rd,
  output logic            wb_reg_write,
  output logic            err_valid,
  output logic [0:1]      err_code,
  output logic [0:ADDR_W-1] err_addr
);

  typedef enum logic [1:0] {IDLE, REQ, RDATA, DONE} state_t;

  state_t state_q, state_d;

  logic [0:ADDR_W-1] addr_q, addr_d;
  logic [0:ADDR_W-1] wdata_q, wdata_d;
  logic [0:3]        be_q, be_d;
  logic              wren_q, wren_d;
  logic [0:4]        rd_q, rd_d;
  logic              reg_write_q, reg_write_d;
  logic [0:1]        size_q, size_d;
  logic              unsigned_q, unsigned_d;

  logic              wb_valid_q, wb_valid_d;
  logic [0:ADDR_W-1] wb_data_q, wb_data_d;
  logic [0:4]        wb_rd_q, wb_rd_d;
  logic              wb_reg_write_q, wb_reg_write_d;
  logic              err_valid_q, err_valid_d;
  logic [0:1]        err_code_q, err_code_d;
  logic [0:ADDR_W-1] err_addr_q, err_addr_d;

  logic [0:1]        lane_in;
  logic              req_misaligned;
  logic [0:3]        req_be;
  logic [0:ADDR_W-1] req_wdata;
  logic [0:7]        ld_byte;
  logic [0:15]       ld_half;
  logic [0:ADDR_W-1] load_value;
  logic              in_req;

  assign lane_in = alu_result[ADDR_W-2:ADDR_W-1];

  // Decode the incoming access: alignment, byte enables and lane-replicated store data
  always_comb begin
    req_misaligned = 1'b0;
    req_be         = 4'b1111;
    req_wdata      = rt_data;
    case (mem_size)
      2'b00: begin
        req_be    = 4'b1000 >> lane_in;
        req_wdata = {4{rt_data[ADDR_W-8:ADDR_W-1]}};
      end
      2'b01: begin
        req_misaligned = alu_result[ADDR_W-1];
        req_be         = alu_result[ADDR_W-2] ? 4'b0011 : 4'b1100;
        req_wdata      = {2{rt_data[ADDR_W-16:ADDR_W-1]}};
      end
      default: begin
        req_misaligned = |lane_in;
      end
    endcase
  end

  // Pick the addressed lane out of the returned word and sign/zero-extend it
  always_comb begin
    case (addr_q[ADDR_W-2:ADDR_W-1])
      2'b00:   ld_byte = dmem_rdata[0:7];
      2'b01:   ld_byte = dmem_rdata[8:15];
      2'b10:   ld_byte = dmem_rdata[16:23];
      default: ld_byte = dmem_rdata[24:31];
    endcase
    ld_half = addr_q[ADDR_W-2] ? dmem_rdata[16:31] : dmem_rdata[0:15];
    case (size_q)
      2'b00:   load_value = unsigned_q ? {24'b0, ld_byte} : {{24{ld_byte[0]}}, ld_byte};
      2'b01:   load_value = unsigned_q ? {16'b0, ld_half} : {{16{ld_half[0]}}, ld_half};
      default: load_value = dmem_rdata;
    endcase
  end

  // Next-state logic; writeback and error pulses default to zero every cycle
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    be_d           = be_q;
    wren_d         = wren_q;
    rd_d           = rd_q;
    reg_write_d    = reg_write_q;
    size_d         = size_q;
    unsigned_d     = unsigned_q;
    wb_valid_d     = 1'b0;
    wb_data_d      = '0;
    wb_rd_d        = '0;
    wb_reg_write_d = 1'b0;
    err_valid_d    = 1'b0;
    err_code_d     = '0;
    err_addr_d     = '0;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (valid_in) begin
          if (!is_load && !is_store) begin
            wb_valid_d     = 1'b1;
            wb_data_d      = alu_result;
            wb_rd_d        = rd_in;
            wb_reg_write_d = reg_write_in;
          end else if (is_load && is_store) begin
            err_valid_d = 1'b1;
            err_code_d  = ERR_CODE_ILLEGAL;
            err_addr_d  = alu_result;
          end else if (req_misaligned) begin
            err_valid_d = 1'b1;
            err_code_d  = ERR_CODE_MISALIGN;
            err_addr_d  = alu_result;
          end else begin
            state_d     = REQ;
            addr_d      = alu_result;
            wdata_d     = req_wdata;
            be_d        = req_be;
            wren_d      = is_store;
            rd_d        = rd_in;
            reg_write_d = reg_write_in;
            size_d      = mem_size;
            unsigned_d  = load_unsigned;
          end
        end
      end
      REQ: begin
        if (!dmem_busy) begin
          if (wren_q) begin
            state_d    = DONE;
            wb_valid_d = 1'b1;
            wb_rd_d    = rd_q;
          end else begin
            state_d = RDATA;
          end
        end
      end
      RDATA: begin
        state_d        = DONE;
        wb_valid_d     = 1'b1;
        wb_data_d      = load_value;
        wb_rd_d        = rd_q;
        wb_reg_write_d = reg_write_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latched instruction and registered outputs; reset abandons any access
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      wdata_q        <= '0;
      be_q           <= '0;
      wren_q         <= 1'b0;
      rd_q           <= '0;
      reg_write_q    <= 1'b0;
      size_q         <= '0;
      unsigned_q     <= 1'b0;
      wb_valid_q     <= 1'b0;
      wb_data_q      <= '0;
      wb_rd_q        <= '0;
      wb_reg_write_q <= 1'b0;
      err_valid_q    <= 1'b0;
      err_code_q     <= '0;
      err_addr_q     <= '0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      be_q           <= be_d;
      wren_q         <= wren_d;
      rd_q           <= rd_d;
      reg_write_q    <= reg_write_d;
      size_q         <= size_d;
      unsigned_q     <= unsigned_d;
      wb_valid_q     <= wb_valid_d;
      wb_data_q      <= wb_data_d;
      wb_rd_q        <= wb_rd_d;
      wb_reg_write_q <= wb_reg_write_d;
      err_valid_q    <= err_valid_d;
      err_code_q     <= err_code_d;
      err_addr_q     <= err_addr_d;
    end
  end

  assign in_req       = (state_q == REQ);
  assign stall_out    = (state_q == REQ) || (state_q == RDATA);
  assign dmem_enable  = in_req;
  assign dmem_wren    = in_req & wren_q;
  assign dmem_addr    = in_req ? {addr_q[0:ADDR_W-3], 2'b00} : '0;
  assign dmem_be      = in_req ? be_q : '0;
  assign dmem_wdata   = in_req ? wdata_q : '0;
  assign wb_valid     = wb_valid_q;
  assign wb_data      = wb_data_q;
  assign wb_rd        = wb_rd_q;
  assign wb_reg_write = wb_reg_write_q;
  assign err_valid    = err_valid_q;
  assign err_code     = err_code_q;
  assign err_addr     = err_addr_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: a scoreboard of expected
// writeback/error packets and memory requests, plus a small memory model.
module tb_mem_access_stage;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        valid_in;
  logic [31:0] alu_result;
  logic [31:0] rt_data;
  logic [4:0]  rd_in;
  logic        reg_write_in;
  logic        is_load;
  logic        is_store;
  logic [1:0]  mem_size;
  logic        load_unsigned;
  logic        stall_out;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_wren;
  logic        dmem_enable;
  logic [31:0] dmem_rdata;
  logic        dmem_busy;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic        err_valid;
  logic [1:0]  err_code;
  logic [31:0] err_addr;

  typedef struct {
    bit          is_err;
    logic [31:0] data;
    bit          chk_data;
    logic [4:0]  rd;
    bit          reg_write;
    logic [1:0]  code;
    logic [31:0] addr;
  } wb_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    bit          wren;
    int          cycles;
  } req_exp_t;

  wb_exp_t     wb_q[$];
  req_exp_t    req_q[$];
  logic [31:0] mem [0:15];
  int          checks = 0;
  int          errors = 0;
  int          busy_left = 0;
  int          req_cycles = 0;
  bit          read_pending = 0;
  logic [31:0] read_word;
  bit          no_stall_expected = 0;
  bit          stall_seen;

  always #5 clock = ~clock;

  mem_access_stage dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .valid_in     (valid_in),
    .alu_result   (alu_result),
    .rt_data      (rt_data),
    .rd_in        (rd_in),
    .reg_write_in (reg_write_in),
    .is_load      (is_load),
    .is_store     (is_store),
    .mem_size     (mem_size),
    .load_unsigned(load_unsigned),
    .stall_out    (stall_out),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_be      (dmem_be),
    .dmem_wren    (dmem_wren),
    .dmem_enable  (dmem_enable),
    .dmem_rdata   (dmem_rdata),
    .dmem_busy    (dmem_busy),
    .wb_valid     (wb_valid),
    .wb_data      (wb_data),
    .wb_rd        (wb_rd),
    .wb_reg_write (wb_reg_write),
    .err_valid    (err_valid),
    .err_code     (err_code),
    .err_addr     (err_addr)
  );

  // Count one comparison and report it when observed and expected differ
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Independent reference for load extraction
  function automatic logic [31:0] loadModel(input logic [31:0] word, input logic [31:0] addr,
                                            input logic [1:0] size, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    case (addr[1:0])
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    h = addr[1] ? word[15:0] : word[31:16];
    if (size == 2'b00) return uns ? {24'h0, b} : {{24{b[7]}}, b};
    if (size == 2'b01) return uns ? {16'h0, h} : {{16{h[15]}}, h};
    return word;
  endfunction

  // Sample the DUT at the falling edge: memory model plus scoreboard pops
  task automatic monitorCycle();
    wb_exp_t     e;
    req_exp_t    r;
    logic [31:0] w;
    int          idx;
    stall_seen = stall_out;
    if (no_stall_expected) checkOutput("stall_out", 32'(stall_out), 32'd0);
    if (req_q.size() == 0) begin
      checkOutput("unexpected_enable", 32'(dmem_enable), 32'd0);
    end else if (dmem_enable) begin
      r = req_q[0];
      req_cycles++;
      checkOutput("dmem_addr", dmem_addr, r.addr);
      checkOutput("dmem_be", 32'(dmem_be), 32'(r.be));
      checkOutput("dmem_wren", 32'(dmem_wren), 32'(r.wren));
      if (r.wren) checkOutput("dmem_wdata", dmem_wdata, r.wdata);
      if (!dmem_busy) begin
        checkOutput("req_cycles", 32'(req_cycles), 32'(r.cycles));
        req_cycles = 0;
        void'(req_q.pop_front());
        idx = int'(r.addr[5:2]);
        if (r.wren) begin
          w = mem[idx];
          for (int k = 0; k < 4; k++)
            if (r.be[3-k]) w[31-8*k -: 8] = r.wdata[31-8*k -: 8];
          mem[idx] = w;
        end else begin
          read_pending = 1;
          read_word = mem[idx];
        end
      end
    end
    if (wb_valid || err_valid) begin
      if (wb_q.size() == 0) begin
        checkOutput("unexpected_wb", 32'(wb_valid), 32'd0);
        checkOutput("unexpected_err", 32'(err_valid), 32'd0);
      end else begin
        e = wb_q.pop_front();
        checkOutput("err_valid", 32'(err_valid), 32'(e.is_err));
        checkOutput("wb_valid", 32'(wb_valid), 32'(!e.is_err));
        if (e.is_err) begin
          checkOutput("err_code", 32'(err_code), 32'(e.code));
          checkOutput("err_addr", err_addr, e.addr);
        end else begin
          checkOutput("wb_reg_write", 32'(wb_reg_write), 32'(e.reg_write));
          checkOutput("wb_rd", 32'(wb_rd), 32'(e.rd));
          if (e.chk_data) checkOutput("wb_data", wb_data, e.data);
        end
      end
    end
  endtask

  // One clock: sample at negedge, then update memory-side inputs after posedge
  task automatic step();
    bit dec;
    @(negedge clock);
    monitorCycle();
    dec = dmem_enable && dmem_busy;
    @(posedge clock);
    #1;
    if (dec && busy_left > 0) busy_left--;
    dmem_busy = (busy_left > 0);
    if (read_pending) begin
      dmem_rdata   = read_word;
      read_pending = 0;
    end else begin
      dmem_rdata = 32'hDEADBEEF;
    end
  endtask

  // Present one instruction, hold it while stalled, then record expectations
  task automatic applyStimulus(input logic [31:0] alu, input logic [31:0] rt, input logic [4:0] rd,
                               input logic rw, input logic ld, input logic st,
                               input logic [1:0] size, input logic uns);
    wb_exp_t  e;
    req_exp_t r;
    int       n = 0;
    bit       mis;
    valid_in = 1; alu_result = alu; rt_data = rt; rd_in = rd; reg_write_in = rw;
    is_load = ld; is_store = st; mem_size = size; load_unsigned = uns;
    do begin
      step();
      n++;
    end while (stall_seen && n < 60);
    checkOutput("accept_timeout", 32'(stall_seen), 32'd0);
    valid_in = 0;
    mis = (size == 2'b01) ? alu[0] : ((size == 2'b00) ? 1'b0 : (alu[1:0] != 2'b00));
    e = '{is_err: 0, data: alu, chk_data: 1, rd: rd, reg_write: rw, code: 2'b00, addr: 32'h0};
    if (!ld && !st) begin
      wb_q.push_back(e);
    end else if (ld && st) begin
      e.is_err = 1; e.code = 2'b10; e.addr = alu;
      wb_q.push_back(e);
    end else if (mis) begin
      e.is_err = 1; e.code = 2'b01; e.addr = alu;
      wb_q.push_back(e);
    end else begin
      r.addr = {alu[31:2], 2'b00};
      r.wren = st;
      r.cycles = busy_left + 1;
      case (size)
        2'b00: begin
          r.wdata = {4{rt[7:0]}};
          case (alu[1:0])
            2'd0: r.be = 4'b1000; 2'd1: r.be = 4'b0100;
            2'd2: r.be = 4'b0010; default: r.be = 4'b0001;
          endcase
        end
        2'b01: begin r.wdata = {2{rt[15:0]}}; r.be = alu[1] ? 4'b0011 : 4'b1100; end
        default: begin r.wdata = rt; r.be = 4'b1111; end
      endcase
      req_q.push_back(r);
      if (st) begin
        e.reg_write = 0; e.chk_data = 0;
      end else begin
        e.data = loadModel(mem[int'(alu[5:2])], alu, size, uns);
      end
      wb_q.push_back(e);
    end
  endtask

  // Idle until every expectation has been consumed, bounded
  task automatic drain();
    int n = 0;
    valid_in = 0;
    while ((wb_q.size() != 0 || req_q.size() != 0) && n < 100) begin
      step();
      n++;
    end
    checkOutput("drain_timeout", 32'(wb_q.size() + req_q.size()), 32'd0);
    step();
    step();
  endtask

  initial begin
    reset_n = 0; valid_in = 0; alu_result = 0; rt_data = 0; rd_in = 0; reg_write_in = 0;
    is_load = 0; is_store = 0; mem_size = 0; load_unsigned = 0;
    dmem_busy = 0; dmem_rdata = 32'hDEADBEEF;
    for (int i = 0; i < 16; i++) mem[i] = 32'hA5A5A5A5;
    mem[0] = 32'h11F23344;
    #2;
    checkOutput("reset_stall", 32'(stall_out), 32'd0);
    checkOutput("reset_enable", 32'(dmem_enable), 32'd0);
    checkOutput("reset_wb_valid", 32'(wb_valid), 32'd0);
    checkOutput("reset_err_valid", 32'(err_valid), 32'd0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset_n = 1;
    step();

    $display("[TB] non-memory ops");
    no_stall_expected = 1;
    applyStimulus(32'h0000002A, 32'h0, 5'd5, 1, 0, 0, 2'b10, 0);
    applyStimulus(32'hCAFEF00D, 32'h0, 5'd31, 1, 0, 0, 2'b10, 0);
    applyStimulus(32'h00000007, 32'h0, 5'd9, 0, 0, 0, 2'b00, 0);
    drain();
    no_stall_expected = 0;

    $display("[TB] byte and half loads");
    applyStimulus(32'h80020001, 32'h0, 5'd3, 1, 1, 0, 2'b00, 0);
    applyStimulus(32'h80020001, 32'h0, 5'd4, 1, 1, 0, 2'b00, 1);
    applyStimulus(32'h80020002, 32'h0, 5'd6, 1, 1, 0, 2'b01, 0);
    applyStimulus(32'h80020000, 32'h0, 5'd7, 1, 1, 0, 2'b01, 1);
    drain();

    $display("[TB] half store with busy memory");
    busy_left = 3;
    dmem_busy = 1;
    applyStimulus(32'h80020006, 32'h0000BEEF, 5'd0, 1, 0, 1, 2'b01, 0);
    drain();
    applyStimulus(32'h80020004, 32'h0, 5'd8, 1, 1, 0, 2'b11, 0);
    drain();

    $display("[TB] misaligned and illegal accesses");
    applyStimulus(32'h80020002, 32'h0, 5'd10, 1, 1, 0, 2'b10, 0);
    applyStimulus(32'h80020003, 32'h0, 5'd11, 1, 1, 0, 2'b01, 0);
    applyStimulus(32'h80020000, 32'h0, 5'd12, 1, 1, 1, 2'b10, 0);
    drain();

    $display("[TB] byte store and read back");
    applyStimulus(32'h80020003, 32'h000000AB, 5'd0, 0, 0, 1, 2'b00, 0);
    applyStimulus(32'h80020003, 32'h0, 5'd13, 1, 1, 0, 2'b00, 1);
    applyStimulus(32'h80020003, 32'h0, 5'd14, 1, 1, 0, 2'b00, 0);
    drain();

    $display("[TB] word load followed by held add");
    mem[0] = 32'h12345678;
    applyStimulus(32'h80020000, 32'h0, 5'd15, 1, 1, 0, 2'b10, 0);
    applyStimulus(32'h00000099, 32'h0, 5'd16, 1, 0, 0, 2'b10, 0);
    drain();

    $display("[TB] reset during load data phase");
    applyStimulus(32'h80020000, 32'h0, 5'd17, 1, 1, 0, 2'b10, 0);
    step();
    checkOutput("rdata_stall", 32'(stall_out), 32'd1);
    reset_n = 0;
    #1;
    checkOutput("midreset_stall", 32'(stall_out), 32'd0);
    checkOutput("midreset_enable", 32'(dmem_enable), 32'd0);
    checkOutput("midreset_wb_valid", 32'(wb_valid), 32'd0);
    checkOutput("midreset_err_valid", 32'(err_valid), 32'd0);
    checkOutput("midreset_dmem_addr", dmem_addr, 32'd0);
    wb_q.delete();
    req_q.delete();
    req_cycles = 0;
    read_pending = 0;
    step();
    step();
    reset_n = 1;
    for (int i = 0; i < 5; i++) step();

    $display("[TB] post-reset sanity");
    applyStimulus(32'h00001234, 32'h0, 5'd2, 1, 0, 0, 2'b10, 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
